rca_seq_ctrl: RTL and testbench
===============================

Name: rca_seq_ctrl

Overview:
Sequencer that time-multiplexes one external 8-bit ripple carry adder to perform NBYTES-wide additions, one byte per clock, LSB first. The carry is held in a register between bytes. Operands enter through a valid/ready handshake, and the result leaves through a second valid/ready handshake. It sits between the operand source and the 8-bit adder datapath, and supplies that adder's x, y and cin inputs.

Parameters:
NBYTES, 4, operand width in bytes; legal values are 1 to 16. W = 8*NBYTES.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  reset; synchronous and active-high
in_valid  input  1  operand request
in_ready  output  1  controller can accept operands
in_a  input  W  operand A
in_b  input  W  operand B
in_cin  input  1  carry-in for byte 0
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_sum  output  W  result
out_cout  output  1  carry-out of the most significant byte
busy  output  1  high in RUN and DONE
add_x  output  8  adder operand x
add_y  output  8  adder operand y
add_cin  output  1  adder carry-in
add_sum  input  8  adder sum; combinational return in the same cycle
add_cout  input  1  adder carry-out; combinational return in the same cycle

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE.
  - a_reg, b_reg, sum_reg, carry_reg and idx are cleared to 0.
  - Outputs after reset: in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0, add_x=0, add_y=0, add_cin=0.
  - Reset in RUN or DONE aborts the operation; the partial result is discarded and never presented.
- States: IDLE, RUN, DONE. All outputs are registered except add_x, add_y and add_cin, which are decoded from state, idx and the operand registers.
- IDLE:
  - in_ready=1. add_x, add_y and add_cin are driven 0.
  - On in_valid=1: capture in_a, in_b and in_cin (into carry_reg); set idx=0; go to RUN.
- RUN, one byte per cycle:
  - Drive add_x = a_reg[8*idx+7:8*idx], add_y = b_reg[8*idx+7:8*idx], add_cin = carry_reg.
  - At the clock edge: sum_reg byte idx <= add_sum; carry_reg <= add_cout; idx <= idx+1.
  - When idx = NBYTES-1, go to DONE instead of incrementing.
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1, out_sum=sum_reg, out_cout=carry_reg.
  - Outputs are held stable while out_ready=0.
  - On out_ready=1: go to IDLE; out_valid drops the next cycle.
- Latency:
  - Accept edge at cycle t. RUN occupies cycles t+1 through t+NBYTES. out_valid rises at cycle t+NBYTES+1.
  - Minimum initiation interval is NBYTES+2 cycles. in_ready returns the cycle after the out handshake; there is no IDLE/DONE overlap.
- Arithmetic:
  - Modulo 2^W. out_cout is the true carry out of bit W-1.
  - The carry is chained across bytes solely via carry_reg; byte boundaries are invisible in the result.
- NBYTES=1: RUN lasts exactly 1 cycle. idx is ceil(log2(NBYTES)) bits wide, minimum 1.
- in_valid asserted during reset is not captured.

Optional Feature:
Macro RCA_SEQ_CTRL_SUB_EN.
- Defined:
  - Adds port in_sub (input, 1), captured with the operands.
  - If in_sub=1: add_y = ~b_reg byte idx, and carry_reg is initialised to 1 (in_cin is ignored).
  - out_sum = A-B mod 2^W. out_cout=1 means no borrow (A>=B unsigned).
  - If in_sub=0: addition, identical to the default build.
- Not defined: no in_sub port; addition only; the datapath contains no inversion logic.

Test Plan:
All scenarios use NBYTES=4.
1. Carry across a byte boundary: accept in_a=0x000000FF, in_b=0x00000001, in_cin=0 at cycle t -> out_valid first high at t+5; out_sum=0x00000100, out_cout=0; add_cin=1 during the byte-1 RUN cycle.
2. Full ripple with carry-out: in_a=0xFFFFFFFF, in_b=0x00000000, in_cin=1 -> out_sum=0x00000000, out_cout=1.
3. Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new data -> out_sum and out_cout stable, in_ready=0, new data not captured. Then raise out_ready=1 -> in_ready=1 in the following cycle.
4. Reset mid-operation: rst=1 during the byte-2 RUN cycle of 0xAAAAAAAA+0x55555555 -> next cycle in IDLE with in_ready=1, out_valid=0, out_sum=0. Then 0x12345678+0x11111111 -> 0x23456789, cout=0.
5. Back-to-back: out_ready tied to 1 with two queued ops, 0x80000000+0x80000000 then 0x00000001+0x00000002 -> results 0x00000000/cout=1 then 0x00000003/cout=0; the second accept occurs exactly 6 cycles after the first.
6. With RCA_SEQ_CTRL_SUB_EN, in_sub=1: 5-7 -> out_sum=0xFFFFFFFE, out_cout=0; 7-5 -> out_sum=0x00000002, out_cout=1.

Source files
------------

// File: rtl/rca_seq_ctrl.sv
// Byte-serial W-bit adder sequencer driving one external 8-bit ripple carry adder.
// Optional macro RCA_SEQ_CTRL_SUB_EN adds an in_sub port for A-B subtraction.
module rca_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_cin,
`ifdef RCA_SEQ_CTRL_SUB_EN
  input  logic                  in_sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  busy,
  output logic [7:0]            add_x,
  output logic [7:0]            add_y,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r, next_state_s;
  logic [W-1:0]    a_r, b_r, sum_r, out_sum_r, sum_next_s;
  logic            carry_r, out_cout_r;
  logic [IW-1:0]   idx_r;
  logic            in_ready_r, out_valid_r, busy_r;
  logic            last_byte_s;
  logic [7:0]      a_byte_s, b_byte_s;
`ifdef RCA_SEQ_CTRL_SUB_EN
  logic            sub_r;
`endif

  function automatic logic [7:0] byte_sel(input logic [W-1:0] vec, input logic [IW-1:0] idx);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IW'(i)) r = vec[8*i +: 8];
      else               r = r;
    end
    return r;
  endfunction

  assign last_byte_s = (idx_r == IW'(NBYTES - 1));
  assign a_byte_s    = byte_sel(a_r, idx_r);
  assign b_byte_s    = byte_sel(b_r, idx_r);

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (in_valid)    next_state_s = RUN;  else next_state_s = IDLE;
      RUN:     if (last_byte_s) next_state_s = DONE; else next_state_s = RUN;
      DONE:    if (out_ready)   next_state_s = IDLE; else next_state_s = DONE;
      default: next_state_s = IDLE;
    endcase
  end

  // Adder operand drive; zero outside RUN so the adder sees a quiet bus
  always_comb begin
    add_x   = 8'd0;
    add_y   = 8'd0;
    add_cin = 1'b0;
    if (state_r == RUN) begin
      add_x   = a_byte_s;
`ifdef RCA_SEQ_CTRL_SUB_EN
      add_y   = sub_r ? ~b_byte_s : b_byte_s;
`else
      add_y   = b_byte_s;
`endif
      add_cin = carry_r;
    end else begin
      add_x   = 8'd0;
      add_y   = 8'd0;
      add_cin = 1'b0;
    end
  end

  // Merge the adder's byte into the running sum at the current index
  always_comb begin
    sum_next_s = sum_r;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_r == IW'(i)) sum_next_s[8*i +: 8] = add_sum;
      else                 sum_next_s[8*i +: 8] = sum_r[8*i +: 8];
    end
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      carry_r     <= 1'b0;
      idx_r       <= '0;
      out_sum_r   <= '0;
      out_cout_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef RCA_SEQ_CTRL_SUB_EN
      sub_r       <= 1'b0;
`endif
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == IDLE);
      out_valid_r <= (next_state_s == DONE);
      busy_r      <= (next_state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r   <= in_a;
            b_r   <= in_b;
            idx_r <= '0;
`ifdef RCA_SEQ_CTRL_SUB_EN
            sub_r   <= in_sub;
            carry_r <= in_sub ? 1'b1 : in_cin;
`else
            carry_r <= in_cin;
`endif
          end
        end
        RUN: begin
          sum_r   <= sum_next_s;
          carry_r <= add_cout;
          if (last_byte_s) begin
            out_sum_r  <= sum_next_s;
            out_cout_r <= add_cout;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        DONE: begin
          out_sum_r <= out_sum_r;
        end
        default: begin
          out_sum_r <= out_sum_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_cout  = out_cout_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench for rca_seq_ctrl (NBYTES=4) with a behavioural 8-bit adder.
module tb_rca_seq_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_cin, in_sub;
  logic [W-1:0]  in_a, in_b, out_sum;
  logic          out_valid, out_ready, out_cout, busy;
  logic [7:0]    add_x, add_y, add_sum;
  logic          add_cin, add_cout;

  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  logic [32:0]   sb_q[$];

  rca_seq_ctrl #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef RCA_SEQ_CTRL_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .busy(busy), .add_x(add_x), .add_y(add_y),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {8'd0, add_cin};

  // Offer one operand set from a negedge; acc = cycle whose closing edge accepts it
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input logic [32:0] exp, input bit push,
                        output int acc, output bit ok);
    ok = 1'b0; acc = -1;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (in_ready === 1'b1) begin acc = cyc; ok = 1'b1; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (ok && push) sb_q.push_back(exp);
  endtask

  task automatic wait_valid(output bit got, output int vcyc);
    got = 1'b0; vcyc = -1;
    for (int n = 0; n < 30; n++) begin
      if (out_valid === 1'b1) begin got = 1'b1; vcyc = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic pop_exp(output logic [32:0] e);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = 33'h1_DEAD_BEEF;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h1;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_hs got rdy=%b vld=%b busy=%b exp 1 0 0", in_ready, out_valid, busy); end
    total++; if (out_sum !== 32'h0 || out_cout !== 1'b0) begin
      bad++; $display("FAIL reset_out got %h/%b exp 0/0", out_sum, out_cout); end
    total++; if (add_x !== 8'h0 || add_y !== 8'h0 || add_cin !== 1'b0) begin
      bad++; $display("FAIL reset_add got %h %h %b exp 0", add_x, add_y, add_cin); end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_nocapture got busy=%b exp 0", busy); end
  endtask

  task automatic test_carry_byte;
    int acc, vcyc; bit ok, got; logic [32:0] e;
    out_ready = 1'b1;
    launch(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 32'h0000_0100}, 1'b1, acc, ok);
    total++; if (!ok) begin bad++; $display("FAIL t1_accept got timeout exp accept"); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy got %b exp 1", busy); end
    got = 1'b0; vcyc = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      if (cyc == acc + 2) begin
        total++; if (add_cin !== 1'b1 || add_x !== 8'h00 || add_y !== 8'h00) begin
          bad++; $display("FAIL t1_byte1 got cin=%b x=%h y=%h exp 1 00 00", add_cin, add_x, add_y); end
      end
      if (out_valid === 1'b1) begin got = 1'b1; vcyc = cyc; end
      else @(negedge clk);
    end
    total++; if (!got || vcyc - acc != 5) begin
      bad++; $display("FAIL t1_latency got %0d exp 5", vcyc - acc); end
    pop_exp(e);
    total++; if ({out_cout, out_sum} !== e) begin
      bad++; $display("FAIL t1_result got %h exp %h", {out_cout, out_sum}, e); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL t1_release got vld=%b rdy=%b exp 0 1", out_valid, in_ready); end
  endtask

  task automatic test_full_ripple;
    int acc, vcyc; bit ok, got; logic [32:0] e;
    out_ready = 1'b1;
    launch(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b1, 32'h0000_0000}, 1'b1, acc, ok);
    wait_valid(got, vcyc);
    total++; if (!ok || !got) begin bad++; $display("FAIL t2_handshake got timeout exp result"); end
    pop_exp(e);
    total++; if ({out_cout, out_sum} !== e) begin
      bad++; $display("FAIL t2_result got %h exp %h", {out_cout, out_sum}, e); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int acc, vcyc; bit ok, got, stray; logic [32:0] e;
    out_ready = 1'b0;
    launch(32'hF0F0_F0F0, 32'h0F0F_0F11, 1'b0, 1'b0, {1'b1, 32'h0000_0001}, 1'b1, acc, ok);
    wait_valid(got, vcyc);
    total++; if (!ok || !got) begin bad++; $display("FAIL t3_handshake got timeout exp result"); end
    pop_exp(e);
    in_a = 32'hDEAD_BEEF; in_b = 32'h0BAD_F00D; in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      total++; if ({out_cout, out_sum} !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL t3_hold got %h vld=%b rdy=%b exp %h 1 0", {out_cout, out_sum}, out_valid, in_ready, e); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL t3_release got rdy=%b vld=%b exp 1 0", in_ready, out_valid); end
    stray = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (out_valid === 1'b1 || busy === 1'b1) stray = 1'b1;
      @(negedge clk);
    end
    total++; if (stray) begin bad++; $display("FAIL t3_nocapture got activity exp idle"); end
  endtask

  task automatic test_reset_mid;
    int acc, vcyc; bit ok, got; logic [32:0] e;
    out_ready = 1'b1;
    launch(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 33'h0, 1'b0, acc, ok);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 32'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL t4_abort got rdy=%b vld=%b sum=%h busy=%b exp 1 0 0 0", in_ready, out_valid, out_sum, busy); end
    launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, {1'b0, 32'h2345_6789}, 1'b1, acc, ok);
    wait_valid(got, vcyc);
    total++; if (!ok || !got || vcyc - acc != 5) begin
      bad++; $display("FAIL t4_latency got %0d exp 5", vcyc - acc); end
    pop_exp(e);
    total++; if ({out_cout, out_sum} !== e) begin
      bad++; $display("FAIL t4_result got %h exp %h", {out_cout, out_sum}, e); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int acc1, acc2, seen; bit ok1, ok2; logic [32:0] e;
    out_ready = 1'b1; seen = 0;
    fork
      begin
        launch(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {1'b1, 32'h0}, 1'b1, acc1, ok1);
        launch(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, {1'b0, 32'h3}, 1'b1, acc2, ok2);
      end
      begin
        for (int n = 0; n < 40 && seen < 2; n++) begin
          if (out_valid === 1'b1) begin
            pop_exp(e);
            total++; if ({out_cout, out_sum} !== e) begin
              bad++; $display("FAIL t5_result%0d got %h exp %h", seen, {out_cout, out_sum}, e); end
            seen++;
          end
          @(negedge clk);
        end
      end
    join
    total++; if (!ok1 || !ok2 || seen != 2) begin
      bad++; $display("FAIL t5_count got %0d results exp 2", seen); end
    total++; if (acc2 - acc1 != 6) begin
      bad++; $display("FAIL t5_interval got %0d exp 6", acc2 - acc1); end
  endtask

  task automatic test_sub;
`ifdef RCA_SEQ_CTRL_SUB_EN
    int acc, vcyc; bit ok, got; logic [32:0] e;
    out_ready = 1'b1;
    launch(32'd5, 32'd7, 1'b0, 1'b1, {1'b0, 32'hFFFF_FFFE}, 1'b1, acc, ok);
    wait_valid(got, vcyc);
    pop_exp(e);
    total++; if (!got || {out_cout, out_sum} !== e) begin
      bad++; $display("FAIL t6_sub_borrow got %h exp %h", {out_cout, out_sum}, e); end
    @(negedge clk);
    launch(32'd7, 32'd5, 1'b0, 1'b1, {1'b1, 32'h0000_0002}, 1'b1, acc, ok);
    wait_valid(got, vcyc);
    pop_exp(e);
    total++; if (!got || {out_cout, out_sum} !== e) begin
      bad++; $display("FAIL t6_sub_pos got %h exp %h", {out_cout, out_sum}, e); end
    @(negedge clk);
    in_sub = 1'b0;
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0; in_cin = 1'b0;
    in_sub = 1'b0; out_ready = 1'b0;
    test_reset();
    test_carry_byte();
    test_full_ripple();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_sub();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
